// File: rtl/row_merge_engine_pkg.sv
// Shared types and helpers for the row slide/merge engine.
// Holds the FSM state encoding, slide-direction constants and the width helper.
package row_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic DIR_LO = 1'b0;
  localparam logic DIR_HI = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/row_merge_engine_if.sv
// Row-in / result-out handshake bundle between the board controller and the engine.
interface row_merge_engine_if #(
  parameter int N = 32'sd4,
  parameter int W = 32'sd12
) ();
  import row_pkg::*;

  localparam int SW = W + clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [N*W-1:0] in_row;
  logic          dir;
  logic          out_valid;
  logic          out_ready;
  logic [N*W-1:0] out_row;
  logic [SW-1:0] score;
  logic          moved;
  logic          ovf;

  modport master (
    output in_valid, in_row, dir, out_ready,
    input  in_ready, out_valid, out_row, score, moved, ovf
  );

  modport slave (
    input  in_valid, in_row, dir, out_ready,
    output in_ready, out_valid, out_row, score, moved, ovf
  );

endinterface

// File: rtl/row_merge_engine_step.sv
// One scan step of the merge: decides what a single incoming tile does to the pending tile.
module row_merge_step #(
  parameter int W = 32'sd12
) (
  input  logic [W-1:0] pend,
  input  logic         pend_v,
  input  logic [W-1:0] t,
  output logic         write_en,
  output logic [W-1:0] write_val,
  output logic [W-1:0] pend_nxt,
  output logic         pend_v_nxt,
  output logic [W:0]   score_inc,
  output logic         ovf
);

  logic [W:0] sum_s;

  // Doubling in W+1 bits keeps the true merged value for the score.
  assign sum_s = {t, 1'b0};

  // Empty tiles pass through; a merged pair clears pend_v so it cannot merge again.
  always_comb begin
    write_en   = 1'b0;
    write_val  = pend;
    pend_nxt   = pend;
    pend_v_nxt = pend_v;
    score_inc  = '0;
    ovf        = 1'b0;
    if (t == '0) begin
      write_en = 1'b0;
    end else if (pend_v && (pend == t)) begin
      write_en   = 1'b1;
      score_inc  = sum_s;
      pend_v_nxt = 1'b0;
      if (sum_s[W]) begin
        write_val = '1;
        ovf       = 1'b1;
      end else begin
        write_val = sum_s[W-1:0];
      end
    end else if (pend_v) begin
      write_en  = 1'b1;
      write_val = pend;
      pend_nxt  = t;
    end else begin
      pend_nxt   = t;
      pend_v_nxt = 1'b1;
    end
  end

endmodule

// File: rtl/row_merge_engine.sv
// Sequential 2048 row slide/merge engine: accepts a row, scans one tile per clock,
// then presents the compacted row with score, moved and overflow flags.
module row_merge_engine
  import row_pkg::*;
#(
  parameter int N = 32'sd4,
  parameter int W = 32'sd12
) (
  input logic              clk,
  input logic              rst,
  row_merge_engine_if.slave bus
);

  localparam int SW = W + clog2(N);
  localparam int CW = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 32'sd1);

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   k_r, wp_r, wp_nxt_s, tile_idx_s;
  logic            dir_r;
  logic [N*W-1:0]  in_row_r, res_r, final_row_s, out_row_r;
  logic [W-1:0]    pend_r, tile_s, write_val_s, pend_nxt_s;
  logic            pend_v_r, write_en_s, pend_v_nxt_s, step_ovf_s;
  logic [W:0]      score_inc_s;
  logic [SW-1:0]   acc_score_r, score_r;
  logic            acc_ovf_r, ovf_r, moved_r;
  logic            accept_s;

  assign bus.in_ready  = (state_r == IDLE) && !rst;
  assign bus.out_valid = (state_r == DONE);
  assign bus.out_row   = out_row_r;
  assign bus.score     = score_r;
  assign bus.moved     = moved_r;
  assign bus.ovf       = ovf_r;

  assign accept_s   = bus.in_valid && bus.in_ready;
  assign tile_idx_s = (dir_r == DIR_HI) ? (LAST - k_r) : k_r;
  assign tile_s     = in_row_r[tile_idx_s*W +: W];
  assign wp_nxt_s   = (dir_r == DIR_HI) ? (wp_r - CW'(1'b1)) : (wp_r + CW'(1'b1));

  row_merge_step #(.W(W)) u_step (
    .pend       (pend_r),
    .pend_v     (pend_v_r),
    .t          (tile_s),
    .write_en   (write_en_s),
    .write_val  (write_val_s),
    .pend_nxt   (pend_nxt_s),
    .pend_v_nxt (pend_v_nxt_s),
    .score_inc  (score_inc_s),
    .ovf        (step_ovf_s)
  );

  // Result row as it stands after the flush write of a still-pending tile.
  always_comb begin
    final_row_s = res_r;
    if (pend_v_r) begin
      final_row_s[wp_r*W +: W] = pend_r;
    end else begin
      final_row_s = res_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = accept_s ? SCAN : IDLE;
      SCAN:    state_nxt_s = (k_r == LAST) ? FLUSH : SCAN;
      FLUSH:   state_nxt_s = DONE;
      DONE:    state_nxt_s = bus.out_ready ? IDLE : DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, work and output registers; reset discards any row in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      k_r         <= '0;
      wp_r        <= '0;
      dir_r       <= DIR_LO;
      in_row_r    <= '0;
      res_r       <= '0;
      pend_r      <= '0;
      pend_v_r    <= 1'b0;
      acc_score_r <= '0;
      acc_ovf_r   <= 1'b0;
      out_row_r   <= '0;
      score_r     <= '0;
      moved_r     <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            in_row_r    <= bus.in_row;
            dir_r       <= bus.dir;
            wp_r        <= (bus.dir == DIR_LO) ? '0 : LAST;
            k_r         <= '0;
            res_r       <= '0;
            pend_r      <= '0;
            pend_v_r    <= 1'b0;
            acc_score_r <= '0;
            acc_ovf_r   <= 1'b0;
          end
        end
        SCAN: begin
          k_r         <= k_r + CW'(1'b1);
          pend_r      <= pend_nxt_s;
          pend_v_r    <= pend_v_nxt_s;
          acc_score_r <= acc_score_r + SW'(score_inc_s);
          acc_ovf_r   <= acc_ovf_r | step_ovf_s;
          if (write_en_s) begin
            res_r[wp_r*W +: W] <= write_val_s;
            wp_r               <= wp_nxt_s;
          end
        end
        FLUSH: begin
          res_r     <= final_row_s;
          pend_v_r  <= 1'b0;
          out_row_r <= final_row_s;
          score_r   <= acc_score_r;
          ovf_r     <= acc_ovf_r;
          moved_r   <= (final_row_s != in_row_r);
        end
        DONE: begin
          pend_v_r <= 1'b0;
        end
        default: begin
          pend_v_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_merge_engine.sv
// Directed and randomized checks of row_merge_engine against a queue-based merge model.
module tb_row_merge_engine;

  localparam int N = 4;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  row_merge_engine_if #(.N(N), .W(W)) bus ();

  row_merge_engine #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [47:0] pk(input int a, input int b, input int c, input int d);
    logic [11:0] a12, b12, c12, d12;
    a12 = a[11:0]; b12 = b[11:0]; c12 = c[11:0]; d12 = d[11:0];
    return {d12, c12, b12, a12};
  endfunction

  // 2048 rule: gather non-empty tiles in slide order, merge equal neighbours once, repack.
  function automatic void model(input logic [47:0] row, input bit d, output logic [47:0] o,
                                output int sc, output bit mv, output bit ov);
    int q[$];
    int m[$];
    int v, i;
    sc = 0; ov = 0; o = '0;
    for (int j = 0; j < 4; j++) begin
      v = int'(row[(d ? 3 - j : j) * 12 +: 12]);
      if (v != 0) q.push_back(v);
    end
    i = 0;
    while (i < q.size()) begin
      if (i + 1 < q.size() && q[i] == q[i + 1]) begin
        v = 2 * q[i];
        sc += v;
        if (v > 4095) begin v = 4095; ov = 1; end
        m.push_back(v);
        i += 2;
      end else begin
        m.push_back(q[i]);
        i += 1;
      end
    end
    for (int j = 0; j < m.size(); j++) o[(d ? 3 - j : j) * 12 +: 12] = 12'(m[j]);
    mv = (o != row);
  endfunction

  function automatic int rand_tile();
    int v;
    v = $urandom_range(0, 7);
    if (v == 0) return 0;
    if (v == 7) return ($urandom_range(0, 1) == 0) ? 2048 : 4095;
    return 1 << $urandom_range(1, 3);
  endfunction

  task automatic run_row(input logic [47:0] row, input bit d, input logic [47:0] er,
                         input int es, input bit em, input bit eo,
                         input int hold, input logic [47:0] pulse_row);
    int cnt;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_row   = row;
    bus.dir      = d;
    cnt = 0;
    while (!bus.in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("accept_wait", cnt < 50, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_row   = {$urandom, $urandom};
    bus.dir      = $urandom_range(0, 1);
    cnt = 0;
    while (!bus.out_valid && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, 5);
    check("out_row", bus.out_row, er);
    check("score", bus.score, es);
    check("moved", bus.moved, em);
    check("ovf", bus.ovf, eo);
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin
        bus.in_valid = 1'b1;
        bus.in_row   = pulse_row;
        bus.dir      = 1'b0;
      end
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_out_row", bus.out_row, er);
      check("hold_score", bus.score, es);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("done_out_valid", bus.out_valid, 0);
    check("done_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    logic [47:0] row, er;
    int es, cnt;
    bit d, em, eo;

    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.dir       = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_row", bus.out_row, 0);
    check("rst_score", bus.score, 0);
    check("rst_moved", bus.moved, 0);
    check("rst_ovf", bus.ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);

    run_row(pk(2, 2, 4, 4), 0, pk(4, 8, 0, 0), 12, 1, 0, 10, pk(2, 4, 8, 16));
    run_row(pk(2, 4, 8, 16), 0, pk(2, 4, 8, 16), 0, 0, 0, 0, '0);
    run_row(pk(2, 2, 2, 2), 0, pk(4, 4, 0, 0), 8, 1, 0, 0, '0);
    run_row(pk(4, 4, 4, 0), 0, pk(8, 4, 0, 0), 8, 1, 0, 0, '0);
    run_row(pk(0, 2, 0, 2), 1, pk(0, 0, 0, 4), 4, 1, 0, 0, '0);
    run_row(pk(2048, 2048, 0, 0), 0, pk(4095, 0, 0, 0), 4096, 1, 1, 0, '0);

    // Abort a row in its second scan cycle.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_row   = pk(8, 8, 2, 2);
    bus.dir      = 1'b0;
    check("abort_ready", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_row", bus.out_row, 0);
    check("abort_score", bus.score, 0);
    check("abort_moved", bus.moved, 0);
    check("abort_ovf", bus.ovf, 0);
    check("abort_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("abort_no_valid", cnt, 0);
    run_row(pk(8, 0, 8, 0), 0, pk(16, 0, 0, 0), 16, 1, 0, 0, '0);

    for (int n = 0; n < 40; n++) begin
      row = pk(rand_tile(), rand_tile(), rand_tile(), rand_tile());
      d   = $urandom_range(0, 1);
      model(row, d, er, es, em, eo);
      run_row(row, d, er, es, em, eo, 0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
